// File: rtl/mcycle_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Signed ops run on magnitudes; the result is sign-corrected when it is registered.
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  input  logic [3:0]       WA3In,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done,
  output logic [3:0]       WA3Out
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_is_div;
  logic             r_is_signed;
  logic             r_sign1;
  logic             r_sign2;
  logic             r_div0;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result1;
  logic [WIDTH-1:0] r_result2;
  logic             r_busy;
  logic             r_done;
  logic [3:0]       r_wa3;

  // Operand magnitudes at capture time
  logic             w_op_signed;
  logic             w_neg1;
  logic             w_neg2;
  logic [WIDTH-1:0] w_mag1;
  logic [WIDTH-1:0] w_mag2;

  assign w_op_signed = ~MCycleOp[0];
  assign w_neg1      = w_op_signed & Operand1[WIDTH-1];
  assign w_neg2      = w_op_signed & Operand2[WIDTH-1];
  assign w_mag1      = w_neg1 ? -Operand1 : Operand1;
  assign w_mag2      = w_neg2 ? -Operand2 : Operand2;

  // One iteration: r_hi holds product-high / partial remainder, r_lo holds product-low / quotient
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_hi_next;
  logic [WIDTH-1:0] w_lo_next;

  assign w_sum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_b : {WIDTH{1'b0}})};
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_b};

  always_comb begin
    w_hi_next = {1'b0, w_sum[WIDTH:2]} ;
    w_lo_next = r_lo;
    if (r_is_div) begin
      // The partial remainder stays below the divisor, so it always fits in WIDTH bits
      if (!w_diff[WIDTH]) begin
        w_hi_next = w_diff[WIDTH-1:0];
        w_lo_next = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_hi_next = w_shift[WIDTH-1:0];
        w_lo_next = {r_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_hi_next = w_sum[WIDTH:1];
      w_lo_next = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  // Sign correction of the final iteration's value
  logic [2*WIDTH-1:0] w_prod_mag;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_neg_res;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_prod_mag = {w_hi_next, w_lo_next};
  assign w_neg_res  = r_is_signed & (r_sign1 ^ r_sign2);
  assign w_prod     = w_neg_res ? -w_prod_mag : w_prod_mag;
  // Divide by zero yields an all-ones quotient regardless of operand signs
  assign w_quo      = (w_neg_res & ~r_div0) ? -w_lo_next : w_lo_next;
  assign w_rem      = (r_is_signed & r_sign1) ? -w_hi_next : w_hi_next;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_is_div    <= 1'b0;
      r_is_signed <= 1'b0;
      r_sign1     <= 1'b0;
      r_sign2     <= 1'b0;
      r_div0      <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_b         <= '0;
      r_result1   <= '0;
      r_result2   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wa3       <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (Start) begin
            r_state     <= S_COMPUTE;
            r_busy      <= 1'b1;
            r_cnt       <= '0;
            r_is_div    <= MCycleOp[1];
            r_is_signed <= w_op_signed;
            r_sign1     <= w_neg1;
            r_sign2     <= w_neg2;
            r_div0      <= (Operand2 == '0);
            r_hi        <= '0;
            r_lo        <= w_mag1;
            r_b         <= w_mag2;
            r_wa3       <= WA3In;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_COMPUTE: begin
          r_hi  <= w_hi_next;
          r_lo  <= w_lo_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            if (r_is_div) begin
              r_result1 <= w_quo;
              r_result2 <= w_rem;
            end else begin
              r_result1 <= w_prod[WIDTH-1:0];
              r_result2 <= w_prod[2*WIDTH-1:WIDTH];
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign Result1 = r_result1;
  assign Result2 = r_result2;
  assign Busy    = r_busy;
  assign Done    = r_done;
  assign WA3Out  = r_wa3;

endmodule

// File: tb/tb_mcycle_unit.sv
// Scoreboard bench for mcycle_unit: expectations queued at Start, compared when Done appears.
module tb_mcycle_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        Start;
  logic [1:0]  MCycleOp;
  logic [31:0] Operand1;
  logic [31:0] Operand2;
  logic [3:0]  WA3In;
  logic [31:0] Result1;
  logic [31:0] Result2;
  logic        Busy;
  logic        Done;
  logic [3:0]  WA3Out;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    logic [3:0]  wa;
  } exp_t;

  exp_t sb_q[$];

  mcycle_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .RESET(RESET), .Start(Start), .MCycleOp(MCycleOp),
    .Operand1(Operand1), .Operand2(Operand2), .WA3In(WA3In),
    .Result1(Result1), .Result2(Result2), .Busy(Busy), .Done(Done), .WA3Out(WA3Out)
  );

  always #5 CLK = ~CLK;

  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] e1, output logic [31:0] e2);
    logic [63:0] p;
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p = '0;
    if (op == 2'b00) p = 64'(sa * sb);
    else if (op == 2'b01) p = {32'b0, a} * {32'b0, b};
    if (!op[1]) begin
      e1 = p[31:0];
      e2 = p[63:32];
    end else if (b == 32'd0) begin
      e1 = 32'hFFFFFFFF;
      e2 = a;
    end else if (op == 2'b10) begin
      q = sa / sb;
      r = sa % sb;
      e1 = 32'(q);
      e2 = 32'(r);
    end else begin
      e1 = a / b;
      e2 = a % b;
    end
  endfunction

  // Drives one Start cycle; returns at the first negedge after the capture edge.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] wa, input logic [31:0] e1, input logic [31:0] e2);
    @(negedge CLK);
    Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b; WA3In = wa;
    sb_q.push_back('{r1: e1, r2: e2, wa: wa});
    @(negedge CLK);
    Start = 1'b0; Operand1 = $urandom; Operand2 = $urandom; WA3In = 4'($urandom);
    MCycleOp = 2'($urandom);
  endtask

  // Counts cycles (current negedge = 1) until Done, bounded.
  task automatic wait_done(output int n, output int busy_n, output int overlap);
    n = 1; busy_n = 0; overlap = 0;
    while (Done !== 1'b1 && n < 80) begin
      if (Busy === 1'b1) busy_n++;
      @(negedge CLK);
      n++;
    end
    if (Busy === 1'b1 && Done === 1'b1) overlap++;
  endtask

  task automatic test_reset();
    RESET = 1'b1; Start = 1'b0; MCycleOp = 2'b00; Operand1 = '0; Operand2 = '0; WA3In = '0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Result1 !== 32'd0 || Result2 !== 32'd0 || WA3Out !== 4'd0) begin
      failures++;
      $display("FAIL reset_state busy=%b done=%b r1=%h r2=%h wa=%h required all zero",
               Busy, Done, Result1, Result2, WA3Out);
    end
    $display("txn reset: busy=%b done=%b r1=%h r2=%h wa=%h", Busy, Done, Result1, Result2, WA3Out);
  endtask

  task automatic test_mul();
    logic [1:0]  ops[3] = '{2'b01, 2'b00, 2'b00};
    logic [31:0] as[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000};
    logic [31:0] bs[3]  = '{32'hFFFFFFFF, 32'd7, 32'h80000000};
    logic [31:0] e1s[3] = '{32'h00000001, 32'hFFFFFFEB, 32'h00000000};
    logic [31:0] e2s[3] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000};
    int n, busy_n, ov;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      start_op(ops[i], as[i], bs[i], 4'(i + 1), e1s[i], e2s[i]);
      wait_done(n, busy_n, ov);
      checks++;
      if (Done !== 1'b1 || n != 33) begin
        failures++;
        $display("FAIL mul_latency[%0d] done=%b cycles=%0d required 33", i, Done, n);
      end
      checks++;
      if (busy_n != 32 || ov != 0) begin
        failures++;
        $display("FAIL mul_busy[%0d] busy_cycles=%0d overlap=%0d required 32 and 0", i, busy_n, ov);
      end
      e = sb_q.pop_front();
      checks++;
      if (Result1 !== e.r1 || Result2 !== e.r2 || WA3Out !== e.wa) begin
        failures++;
        $display("FAIL mul_result[%0d] got %h_%h wa=%h required %h_%h wa=%h",
                 i, Result2, Result1, WA3Out, e.r2, e.r1, e.wa);
      end
      $display("txn mul op=%b %h*%h -> %h_%h wa=%h cycles=%0d", ops[i], as[i], bs[i], Result2, Result1, WA3Out, n);
    end
    // Done is a single-cycle pulse and results hold in IDLE
    repeat (3) @(negedge CLK);
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0 || Result1 !== e.r1 || Result2 !== e.r2 || WA3Out !== e.wa) begin
      failures++;
      $display("FAIL mul_hold done=%b busy=%b got %h_%h required done=0 busy=0 %h_%h",
               Done, Busy, Result2, Result1, e.r2, e.r1);
    end
  endtask

  task automatic test_div();
    logic [1:0]  ops[5] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b11};
    logic [31:0] as[5]  = '{32'hFFFFFFF9, 32'h80000000, 32'd7, 32'd100, 32'hFFFFFFFF};
    logic [31:0] bs[5]  = '{32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd7, 32'd1};
    logic [31:0] e1s[5] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFD, 32'd14, 32'hFFFFFFFF};
    logic [31:0] e2s[5] = '{32'hFFFFFFFF, 32'h00000000, 32'd1, 32'd2, 32'd0};
    int n, busy_n, ov;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      start_op(ops[i], as[i], bs[i], 4'(i + 6), e1s[i], e2s[i]);
      wait_done(n, busy_n, ov);
      e = sb_q.pop_front();
      checks++;
      if (Done !== 1'b1 || Result1 !== e.r1 || Result2 !== e.r2 || WA3Out !== e.wa) begin
        failures++;
        $display("FAIL div_result[%0d] done=%b got q=%h r=%h wa=%h required q=%h r=%h wa=%h",
                 i, Done, Result1, Result2, WA3Out, e.r1, e.r2, e.wa);
      end
      $display("txn div op=%b %h/%h -> q=%h r=%h cycles=%0d", ops[i], as[i], bs[i], Result1, Result2, n);
    end
  endtask

  task automatic test_div0();
    logic [1:0]  ops[2] = '{2'b11, 2'b10};
    logic [31:0] as[2]  = '{32'd100, 32'hFFFFFFFB};
    logic [31:0] e2s[2] = '{32'd100, 32'hFFFFFFFB};
    int n, busy_n, ov;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      start_op(ops[i], as[i], 32'd0, 4'hC, 32'hFFFFFFFF, e2s[i]);
      wait_done(n, busy_n, ov);
      e = sb_q.pop_front();
      checks++;
      if (Done !== 1'b1 || Result1 !== e.r1 || Result2 !== e.r2) begin
        failures++;
        $display("FAIL div0[%0d] done=%b got q=%h r=%h required q=%h r=%h",
                 i, Done, Result1, Result2, e.r1, e.r2);
      end
      $display("txn div0 op=%b %h/0 -> q=%h r=%h", ops[i], as[i], Result1, Result2);
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b, e1, e2;
    int n, busy_n, ov;
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i == 4) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      model(op, a, b, e1, e2);
      start_op(op, a, b, 4'(i), e1, e2);
      wait_done(n, busy_n, ov);
      e = sb_q.pop_front();
      checks++;
      if (Done !== 1'b1 || Result1 !== e.r1 || Result2 !== e.r2 || WA3Out !== e.wa) begin
        failures++;
        $display("FAIL random[%0d] op=%b a=%h b=%h got %h/%h wa=%h required %h/%h wa=%h",
                 i, op, a, b, Result1, Result2, WA3Out, e.r1, e.r2, e.wa);
      end
      $display("txn random op=%b a=%h b=%h -> r1=%h r2=%h", op, a, b, Result1, Result2);
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] e1, e2;
    int n, busy_n, ov;
    exp_t e;
    model(2'b01, 32'd1234, 32'd5678, e1, e2);
    start_op(2'b01, 32'd1234, 32'd5678, 4'h4, e1, e2);
    repeat (4) @(negedge CLK);
    Start = 1'b1; MCycleOp = 2'b11; Operand1 = 32'd99; Operand2 = 32'd3; WA3In = 4'h3;
    @(negedge CLK);
    Start = 1'b0;
    checks++;
    if (WA3Out !== 4'h4 || Busy !== 1'b1) begin
      failures++;
      $display("FAIL ignore_midstart wa=%h busy=%b required wa=4 busy=1", WA3Out, Busy);
    end
    wait_done(n, busy_n, ov);
    e = sb_q.pop_front();
    checks++;
    if (Done !== 1'b1 || n + 5 != 33) begin
      failures++;
      $display("FAIL ignore_latency done=%b cycles=%0d required 33", Done, n + 5);
    end
    checks++;
    if (Result1 !== e.r1 || Result2 !== e.r2 || WA3Out !== e.wa) begin
      failures++;
      $display("FAIL ignore_result got %h_%h wa=%h required %h_%h wa=%h",
               Result2, Result1, WA3Out, e.r2, e.r1, e.wa);
    end
    $display("txn ignored-start: r1=%h r2=%h wa=%h", Result1, Result2, WA3Out);
  endtask

  task automatic test_back_to_back();
    int n, busy_n, ov;
    exp_t e;
    start_op(2'b00, 32'hFFFFFFFD, 32'd7, 4'h5, 32'hFFFFFFEB, 32'hFFFFFFFF);
    wait_done(n, busy_n, ov);
    e = sb_q.pop_front();
    checks++;
    if (Done !== 1'b1 || Result1 !== e.r1 || Result2 !== e.r2 || WA3Out !== 4'h5) begin
      failures++;
      $display("FAIL b2b_first done=%b got %h_%h wa=%h required %h_%h wa=5",
               Done, Result2, Result1, WA3Out, e.r2, e.r1);
    end
    // Start issued during the Done cycle
    Start = 1'b1; MCycleOp = 2'b01; Operand1 = 32'hFFFFFFFF; Operand2 = 32'hFFFFFFFF; WA3In = 4'hA;
    sb_q.push_back('{r1: 32'h00000001, r2: 32'hFFFFFFFE, wa: 4'hA});
    @(negedge CLK);
    Start = 1'b0;
    checks++;
    if (Busy !== 1'b1 || Done !== 1'b0 || WA3Out !== 4'hA || Result1 !== 32'hFFFFFFEB) begin
      failures++;
      $display("FAIL b2b_accept busy=%b done=%b wa=%h r1=%h required busy=1 done=0 wa=a r1=ffffffeb",
               Busy, Done, WA3Out, Result1);
    end
    wait_done(n, busy_n, ov);
    e = sb_q.pop_front();
    checks++;
    if (Done !== 1'b1 || n != 33 || busy_n != 32) begin
      failures++;
      $display("FAIL b2b_latency done=%b cycles=%0d busy=%0d required 33 and 32", Done, n, busy_n);
    end
    checks++;
    if (Result1 !== e.r1 || Result2 !== e.r2 || WA3Out !== e.wa) begin
      failures++;
      $display("FAIL b2b_second got %h_%h wa=%h required %h_%h wa=%h",
               Result2, Result1, WA3Out, e.r2, e.r1, e.wa);
    end
    $display("txn back-to-back: r1=%h r2=%h wa=%h cycles=%0d", Result1, Result2, WA3Out, n);
  endtask

  task automatic test_reset_abort();
    int n, busy_n, ov, seen;
    exp_t e;
    start_op(2'b01, 32'd5, 32'd6, 4'h7, 32'd30, 32'd0);
    repeat (9) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    void'(sb_q.pop_back());
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Result1 !== 32'd0 || Result2 !== 32'd0 || WA3Out !== 4'd0) begin
      failures++;
      $display("FAIL abort_state busy=%b done=%b r1=%h r2=%h wa=%h required all zero",
               Busy, Done, Result1, Result2, WA3Out);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (Done === 1'b1 || Busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL abort_no_done active_cycles=%0d required 0", seen);
    end
    start_op(2'b11, 32'd1000, 32'd33, 4'h9, 32'd30, 32'd10);
    wait_done(n, busy_n, ov);
    e = sb_q.pop_front();
    checks++;
    if (Done !== 1'b1 || n != 33 || Result1 !== e.r1 || Result2 !== e.r2 || WA3Out !== e.wa) begin
      failures++;
      $display("FAIL abort_restart done=%b cycles=%0d got %h/%h wa=%h required 33 %h/%h wa=%h",
               Done, n, Result1, Result2, WA3Out, e.r1, e.r2, e.wa);
    end
    $display("txn reset-abort then 1000/33 -> q=%h r=%h cycles=%0d", Result1, Result2, n);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div0();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mcycle_unit.md
# mcycle_unit

Iterative multi-cycle multiply/divide unit for the pipelined ARM-style core, in parallel with the single-cycle ALU in the Execute stage. It accepts one operation at a time and computes it over WIDTH cycles using shift-add multiplication or restoring division. It produces Busy, Done and the destination tag consumed by the hazard unit for stall and interlock decisions. Results are held until the next accepted operation so that the Writeback path can read them.

## Interface
- WIDTH, 32, operand/result width in bits; must be ≥ 2. The iteration counter is $clog2(WIDTH)+1 bits.
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- Start  in  1  request; sampled only in IDLE or DONE.
- MCycleOp  in  2  operation code:
  - 00 signed multiply
  - 01 unsigned multiply
  - 10 signed divide
  - 11 unsigned divide
- Operand1  in  WIDTH  multiplicand or dividend.
- Operand2  in  WIDTH  multiplier or divisor.
- WA3In  in  4  destination register tag of the requesting instruction.
- Result1  out  WIDTH  low product word or quotient.
- Result2  out  WIDTH  high product word or remainder.
- Busy  out  1  high while an operation is iterating.
- Done  out  1  one-cycle pulse when Result1/Result2 become valid.
- WA3Out  out  4  tag of the accepted operation, driven to the hazard unit as MCycleWA3.

## Operation
- State machine has three states: IDLE, COMPUTE and DONE.
- IDLE:
  - Start=1 captures MCycleOp, Operand1, Operand2 and WA3In, clears the counter, and moves to COMPUTE.
  - Otherwise the unit stays in IDLE.
- COMPUTE:
  - One iteration per cycle.
  - After the WIDTH-th iteration the unit moves to DONE.
  - Start is ignored and captured inputs are unaffected.
- DONE:
  - Done=1 for exactly one cycle.
  - Start=1 is accepted exactly as in IDLE, allowing back-to-back operations; otherwise the unit returns to IDLE.
- Signed operations (ops 00 and 10):
  - At capture, operands are converted to magnitudes and their sign bits are recorded.
  - The unsigned core runs on the magnitudes; the result is conditionally negated when it is registered.
- Multiply:
  - Full 2·WIDTH-bit product; Result1 = product[WIDTH-1:0], Result2 = product[2·WIDTH-1:WIDTH].
  - For signed ops the product is negated iff the operand signs differ.
- Divide:
  - Restoring division, one quotient bit per iteration.
  - Signed quotient truncates toward zero and is negated iff the operand signs differ.
  - Signed remainder takes the sign of the dividend.
- Divide by zero: quotient = all ones, remainder = Operand1 unmodified, for both signed and unsigned ops.
- Signed overflow (most-negative ÷ −1): quotient = most-negative value, remainder = 0; this falls out of the magnitude scheme with no special case.
- Result1, Result2 and WA3Out hold their values through IDLE until the next accepted Start.
- WA3Out updates on the capture edge.

## Timing
- Reset values: state=IDLE; Busy, Done, Result1, Result2 and WA3Out all 0.
- RESET during COMPUTE or DONE aborts the operation; no Done pulse is produced. RESET has priority over Start.
- Busy and Done are decoded from registered state only; there are no combinational paths from inputs to outputs.
- Latency and handshake, with Start accepted at rising edge k:
  - Busy=1 for the WIDTH cycles following edge k.
  - Done=1 in cycle k+WIDTH+1 (the cycle after edge k+WIDTH), so the initiation-to-Done latency is WIDTH+1 cycles.
  - Results are valid from the Done cycle onward.
- Busy and Done are never asserted together.
- A back-to-back Start in the DONE cycle gives Busy=1 from the next cycle. The Done pulse is still produced, and the previous results remain visible during that Done cycle.
- Throughput: one operation per WIDTH+1 cycles.

## Test plan
- Unsigned multiply: op=01, 0xFFFFFFFF × 0xFFFFFFFF -> Result1=0x00000001, Result2=0xFFFFFFFE; Done exactly 33 cycles after the Start cycle; Busy high for 32 cycles.
- Signed multiply: op=00, −3 × 7 -> Result1=0xFFFFFFEB, Result2=0xFFFFFFFF. Also 0x80000000 × 0x80000000 -> Result1=0x00000000, Result2=0x40000000.
- Signed divide: op=10, −7 ÷ 2 -> Result1=0xFFFFFFFD, Result2=0xFFFFFFFF. Also 0x80000000 ÷ 0xFFFFFFFF -> Result1=0x80000000, Result2=0.
- Divide by zero:
  - Unsigned 100 ÷ 0 -> Result1=0xFFFFFFFF, Result2=100.
  - Signed −5 ÷ 0 -> Result1=0xFFFFFFFF, Result2=0xFFFFFFFB.
- Handshake:
  - Start with different operands and WA3In mid-COMPUTE -> ignored; the original result and WA3Out are produced.
  - Start asserted in the DONE cycle -> accepted; the second Done arrives 33 cycles later.
  - WA3In=0xA is reflected on WA3Out from the cycle after capture.
- Reset: assert RESET for one cycle 10 cycles into COMPUTE -> next cycle Busy=0, Done=0, results=0, WA3Out=0; no Done pulse follows; a new Start completes normally.
